// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the boot-time program loader.
//   ADDR_W : instruction-memory address width
//   DATA_W : byte / instruction width
//   DEPTH  : largest program accepted, in bytes
//   ld_state_t : loader FSM state encoding
package prog_loader_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a framed byte stream (LEN, LEN payload
// bytes, XOR checksum) and writes the payload into instruction memory starting
// at address 0. The CPU is held in reset until a frame has been loaded and its
// checksum verified.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-low
//   start    : one-cycle pulse that begins a load (from IDLE or ERR)
//   s_valid  : stream byte valid
//   s_data   : stream byte
//   s_ready  : loader accepts a byte this cycle
//   mem_we   : instruction-memory write enable
//   mem_addr : instruction-memory write address
//   mem_din  : instruction-memory write data
//   cpu_hold : 1 keeps the CPU in reset
//   done     : frame loaded and checksum matched (sticky until reset)
//   err      : bad length or checksum mismatch
//
// state   | meaning
// --------+-----------------------------------------------
// LD_IDLE | waiting for start after reset
// LD_LEN  | expecting the length byte
// LD_DATA | receiving payload bytes, writing memory
// LD_CSUM | expecting the checksum byte
// LD_DONE | program verified, CPU released
// LD_ERR  | frame rejected, waiting for a new start
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  ld_state_t         state;
  ld_state_t         state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] csum;
  logic              acc;

  assign acc = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE: if (start) state_nxt = LD_LEN;
      LD_LEN:
        if (acc) begin
          if (s_data == '0 || s_data > DATA_W'(DEPTH)) state_nxt = LD_ERR;
          else                                         state_nxt = LD_DATA;
        end
      // cnt still holds the index of the byte being accepted
      LD_DATA: if (acc && (cnt + (ADDR_W+1)'(1)) == len) state_nxt = LD_CSUM;
      LD_CSUM:
        if (acc) begin
          if (s_data == csum) state_nxt = LD_DONE;
          else                state_nxt = LD_ERR;
        end
      LD_DONE: state_nxt = LD_DONE;
      LD_ERR:  if (start) state_nxt = LD_LEN;
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LD_IDLE;
      cnt      <= '0;
      len      <= '0;
      csum     <= '0;
      s_ready  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      s_ready  <= (state_nxt == LD_LEN) || (state_nxt == LD_DATA) || (state_nxt == LD_CSUM);
      cpu_hold <= (state_nxt != LD_DONE);
      done     <= (state_nxt == LD_DONE);
      err      <= (state_nxt == LD_ERR);
      mem_we   <= 1'b0;

      if ((state == LD_IDLE || state == LD_ERR) && start) begin
        cnt  <= '0;
        csum <= '0;
      end

      if (state == LD_LEN && acc && state_nxt == LD_DATA) begin
        len  <= s_data[ADDR_W:0];
        csum <= s_data;
      end

      if (state == LD_DATA && acc) begin
        mem_we   <= 1'b1;
        mem_addr <= cnt[ADDR_W-1:0];
        mem_din  <= s_data;
        csum     <= csum ^ s_data;
        cnt      <= cnt + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. A driver task sends framed byte streams; the
// reference model derives expected memory writes and final status from the
// frame contents alone. Writes are queued and checked by an independent
// monitor that watches the memory write port.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_din;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  logic [12:0] exp_q[$];   // {addr, data}

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_din);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          failures++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   mem_addr, mem_din, e[12:8], e[7:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got s_ready=%b expected 1 within 64 cycles", s_ready);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic rand_payload(input int n, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random gaps.
  // mid_start pulses start after the first payload byte; it must be ignored.
  task automatic do_frame(input logic [7:0] len_b, input logic [7:0] pl[$],
                          input logic [7:0] cs_b, input int gap_mode,
                          input bit mid_start, input string tag);
    logic [7:0] model_cs;
    bit         len_ok;
    bit         exp_done;
    len_ok = (len_b != 0) && (len_b <= 8'd32);
    pulse_start();
    send_byte(len_b);
    if (!len_ok) begin
      @(negedge clk);
      s_valid = 1'b0;
      check({tag, "_err"},      err,      1);
      check({tag, "_done"},     done,     0);
      check({tag, "_hold"},     cpu_hold, 1);
      check({tag, "_ready"},    s_ready,  0);
      return;
    end
    model_cs = len_b;
    for (int i = 0; i < int'(len_b); i++) begin
      model_cs ^= pl[i];
      exp_q.push_back({5'(i), pl[i]});
    end
    exp_done = (cs_b == model_cs);
    for (int i = 0; i < int'(len_b); i++) begin
      if (i > 0 && gap_mode == 1) idle(1);
      if (i > 0 && gap_mode == 2 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_byte(pl[i]);
      if (i == 0 && mid_start) pulse_start();
    end
    if (gap_mode != 0) idle(1);
    send_byte(cs_b);
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_done"},  done,     exp_done);
    check({tag, "_err"},   err,      !exp_done);
    check({tag, "_hold"},  cpu_hold, !exp_done);
    check({tag, "_ready"}, s_ready,  0);
    check({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] cs;
    int         w0;
    int         len;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", s_ready,  0);
    check("rst_we",    mem_we,   0);
    check("rst_addr",  mem_addr, 0);
    check("rst_din",   mem_din,  0);
    check("rst_hold",  cpu_hold, 1);
    check("rst_done",  done,     0);
    check("rst_err",   err,      0);
    rst = 1'b1;

    // known frame
    pl = '{8'h20, 8'h41, 8'hE5};
    do_frame(8'h03, pl, 8'h87, 0, 0, "t1");

    // wrong checksum, then recover from ERR with start
    do_reset();
    exp_q = {};
    do_frame(8'h03, pl, 8'h88, 0, 0, "t2bad");
    do_frame(8'h03, pl, 8'h87, 0, 0, "t2good");

    // bad lengths produce no writes
    do_reset();
    w0 = wr_count;
    do_frame(8'h00, pl, 8'h00, 0, 0, "t3len0");
    do_frame(8'h21, pl, 8'h00, 0, 0, "t3len33");
    check("t3_no_writes", wr_count - w0, 0);

    // maximum length frame
    rand_payload(32, pl);
    cs = 8'h20;
    foreach (pl[i]) cs ^= pl[i];
    do_frame(8'h20, pl, cs, 0, 0, "t3len32");

    // alternating valid during payload
    do_reset();
    rand_payload(6, pl);
    cs = 8'h06;
    foreach (pl[i]) cs ^= pl[i];
    do_frame(8'h06, pl, cs, 1, 0, "t4");

    // reset in the middle of a frame
    do_reset();
    rand_payload(5, pl);
    pulse_start();
    send_byte(8'h05);
    exp_q.push_back({5'd0, pl[0]});
    exp_q.push_back({5'd1, pl[1]});
    send_byte(pl[0]);
    send_byte(pl[1]);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready", s_ready,  0);
    check("t5_hold",  cpu_hold, 1);
    check("t5_we",    mem_we,   0);
    check("t5_qempty", exp_q.size(), 0);
    rst = 1'b1;
    rand_payload(4, pl);
    cs = 8'h04;
    foreach (pl[i]) cs ^= pl[i];
    do_frame(8'h04, pl, cs, 0, 0, "t5reload");

    // start during DATA and DONE is ignored
    do_reset();
    rand_payload(4, pl);
    cs = 8'h04;
    foreach (pl[i]) cs ^= pl[i];
    do_frame(8'h04, pl, cs, 0, 1, "t6");
    pulse_start();
    repeat (3) @(negedge clk);
    check("t6_done_sticky", done,    1);
    check("t6_ready",       s_ready, 0);
    check("t6_hold",        cpu_hold, 0);
    do_reset();
    @(negedge clk);
    check("t6_done_cleared", done, 0);

    // randomized frames
    for (int k = 0; k < 12; k++) begin
      do_reset();
      if ($urandom_range(0, 5) == 0) len = $urandom_range(33, 255);
      else                           len = $urandom_range(1, 32);
      rand_payload((len > 32) ? 0 : len, pl);
      cs = 8'(len);
      foreach (pl[i]) cs ^= pl[i];
      if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
      do_frame(8'(len), pl, cs, 2, 0, $sformatf("rnd%0d", k));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
